// File: rtl/serial_tx_shifter.sv
// LSB-first serializer with optional even-parity bit, handshake on din_valid/din_ready.
// Define SERIAL_TX_PARITY_EN to append the parity bit after the data bits.
module serial_tx_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             sactive,
    output logic             done,
    output logic [7:0]       frame_cnt
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bitcnt;
`ifdef SERIAL_TX_PARITY_EN
    logic             xacc;
`endif

    // shreg[0] is the bit on the wire; it is zero whenever no frame is active.
    assign x         = shreg[0];
    assign din_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
`ifdef SERIAL_TX_PARITY_EN
            xacc      <= 1'b0;
`endif
            sactive   <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        state   <= SHIFT;
                        shreg   <= din;
                        bitcnt  <= '0;
`ifdef SERIAL_TX_PARITY_EN
                        xacc    <= 1'b0;
`endif
                        sactive <= 1'b1;
                    end
                end
                SHIFT: begin
`ifdef SERIAL_TX_PARITY_EN
                    xacc <= xacc ^ shreg[0];
`endif
                    if (bitcnt == LAST_BIT) begin
                        bitcnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
                        // Parity includes the last data bit, which is still on the wire.
                        state  <= PARITY;
                        shreg  <= {{(WIDTH-1){1'b0}}, xacc ^ shreg[0]};
`else
                        state     <= IDLE;
                        shreg     <= '0;
                        sactive   <= 1'b0;
                        done      <= 1'b1;
                        frame_cnt <= frame_cnt + 8'd1;
`endif
                    end else begin
                        bitcnt <= bitcnt + CW'(1);
                        shreg  <= shreg >> 1;
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    state     <= IDLE;
                    shreg     <= '0;
                    sactive   <= 1'b0;
                    done      <= 1'b1;
                    frame_cnt <= frame_cnt + 8'd1;
                end
`endif
                default: begin
                    state   <= IDLE;
                    shreg   <= '0;
                    sactive <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Directed self-checking bench for serial_tx_shifter (WIDTH=8); follows SERIAL_TX_PARITY_EN.
module tb_serial_tx_shifter;

`ifdef SERIAL_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       x;
    logic       sactive;
    logic       done;
    logic [7:0] frame_cnt;

    int         checks;
    int         failures;
    logic [7:0] expCnt;

    serial_tx_shifter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x         (x),
        .sactive   (sactive),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Called at a negedge with the block idle; returns at the negedge of the done cycle.
    task automatic applyStimulus(input logic [7:0] word, input logic par,
                                 input bit midValid, input bit hold);
        checkOutput("ready_idle", {7'd0, din_ready}, 8'd1);
        din       = word;
        din_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checkOutput("sactive_bit", {7'd0, sactive}, 8'd1);
            checkOutput("data_bit", {7'd0, x}, {7'd0, word[i]});
            checkOutput("ready_busy", {7'd0, din_ready}, 8'd0);
            checkOutput("done_busy", {7'd0, done}, 8'd0);
            if (midValid && i == 3) begin
                din       = 8'hFF;
                din_valid = 1'b1;
            end else begin
                din       = hold ? word : ~word;
                din_valid = hold;
            end
            @(negedge clk);
        end
        if (PAR_EN) begin
            checkOutput("sactive_par", {7'd0, sactive}, 8'd1);
            checkOutput("parity_bit", {7'd0, x}, {7'd0, par});
            @(negedge clk);
        end
        expCnt++;
        checkOutput("done_pulse", {7'd0, done}, 8'd1);
        checkOutput("sactive_end", {7'd0, sactive}, 8'd0);
        checkOutput("x_end", {7'd0, x}, 8'd0);
        checkOutput("frame_cnt", frame_cnt, expCnt);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        expCnt    = 8'd0;
        rst       = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;
        #1;
        checkOutput("rst_x", {7'd0, x}, 8'd0);
        checkOutput("rst_sactive", {7'd0, sactive}, 8'd0);
        checkOutput("rst_done", {7'd0, done}, 8'd0);
        checkOutput("rst_cnt", frame_cnt, 8'd0);
        checkOutput("rst_ready", {7'd0, din_ready}, 8'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] basic frames");
        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0);
        din_valid = 1'b0;
        @(negedge clk);
        checkOutput("done_once", {7'd0, done}, 8'd0);
        applyStimulus(8'h07, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);

        $display("[TB] mid-frame din_valid ignored");
        applyStimulus(8'h81, 1'b0, 1'b1, 1'b0);
        din_valid = 1'b0;
        @(negedge clk);
        checkOutput("no_extra_frame", {7'd0, sactive}, 8'd0);
        @(negedge clk);
        checkOutput("no_extra_cnt", frame_cnt, expCnt);

        $display("[TB] back-to-back with held valid");
        applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h01, 1'b1, 1'b0, 1'b1);
        din_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_idle", {7'd0, sactive}, 8'd0);

        $display("[TB] reset mid-frame");
        din       = 8'h3C;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("abort_bit", {7'd0, x}, {7'd0, din[i]});
            if (i < 4) @(negedge clk);
        end
        #1 rst = 1'b1;
        #1;
        expCnt = 8'd0;
        checkOutput("abort_x", {7'd0, x}, 8'd0);
        checkOutput("abort_sactive", {7'd0, sactive}, 8'd0);
        checkOutput("abort_cnt", frame_cnt, expCnt);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_no_done", {7'd0, done}, 8'd0);
        checkOutput("abort_cnt2", frame_cnt, expCnt);
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);

        $display("[TB] frame counter wrap");
        for (int f = 0; f < 255; f++)
            applyStimulus(8'h5B, 1'b1, 1'b0, 1'b0);
        checkOutput("cnt_wrap", frame_cnt, 8'd0);
        din_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_tx_shifter.md
SERIAL_TX_SHIFTER -- requirements
Module: serial_tx_shifter

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits per frame (legal range 2..16).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset; the block has one clock, and reset is asynchronous and active-high.
REQ-004 Port: din  input  WIDTH  parallel word to serialize.
REQ-005 Port: din_valid  input  1  producer offers din this cycle.
REQ-006 Port: din_ready  output  1  block accepts a word this cycle.
REQ-007 Port: x  output  1  serial bit stream, sized to drive a downstream parity detector's x input directly.
REQ-008 Port: sactive  output  1  high while x carries a frame bit (data or parity).
REQ-009 Port: done  output  1  one-cycle pulse after the final bit of a frame.
REQ-010 Port: frame_cnt  output  8  count of completed frames.

Function
REQ-011 States SHALL be IDLE, SHIFT, PARITY; all outputs registered.
REQ-012 din_ready SHALL be 1 only in IDLE.
REQ-013 A word SHALL be accepted on a rising edge where din_valid=1 and din_ready=1; din is captured into a WIDTH-bit shift register and state goes to SHIFT.
REQ-014 In SHIFT, x SHALL present din[0] in the first cycle after acceptance, then din[1], and so on, LSB first, one bit per clock (latency 1 cycle from the accept edge).
REQ-015 A bit counter SHALL count 0..WIDTH-1 in SHIFT; after bit WIDTH-1 the next state is PARITY (macro defined) or IDLE (macro undefined).
REQ-016 A running XOR of transmitted data bits SHALL be kept and cleared on each accept.
REQ-017 In PARITY, x SHALL equal XOR of all WIDTH data bits (even parity: total ones in data+parity is even), for exactly one cycle, then IDLE.
REQ-018 sactive SHALL be 1 in SHIFT and PARITY, 0 in IDLE; x SHALL be 0 whenever sactive=0.
REQ-019 done SHALL pulse high for exactly the first IDLE cycle following a completed frame, else 0.
REQ-020 frame_cnt SHALL increment by 1 in the cycle done is high, wrapping 255->0.
REQ-021 din_valid while not in IDLE SHALL be ignored (no capture, no side effect); din may change freely outside the accept edge.
REQ-022 din_valid=1 held continuously SHALL yield back-to-back frames with exactly one IDLE cycle between them (accept occurs in that IDLE cycle, coincident with done).
REQ-023 Frame period SHALL be WIDTH+2 cycles with parity, WIDTH+1 without.

Reset
REQ-024 rst=1 SHALL asynchronously force state IDLE, shift register 0, bit counter 0, XOR 0, x=0, sactive=0, done=0, frame_cnt=0, din_ready=1 (combinational from IDLE).
REQ-025 rst asserted mid-frame SHALL abort the frame immediately; the aborted frame produces no done pulse and no frame_cnt increment.
REQ-026 First accept after reset release SHALL be possible on the first rising edge with rst=0.

Configuration
REQ-027 Macro SERIAL_TX_PARITY_EN defined: PARITY state present, parity bit appended per REQ-017, period WIDTH+2.
REQ-028 Macro SERIAL_TX_PARITY_EN undefined: PARITY state and XOR logic absent; SHIFT goes directly to IDLE after bit WIDTH-1, period WIDTH+1; all other behaviour unchanged.

Verification
REQ-029 WIDTH=8, macro defined, accept din=8'hA5 -> x over 9 cycles = 1,0,1,0,0,1,0,1,0; sactive high 9 cycles; done pulses once; frame_cnt=1.
REQ-030 Accept din=8'h07 -> data 1,1,1,0,0,0,0,0, then parity bit 1; accept din=8'h00 -> nine zeros with sactive=1.
REQ-031 din_valid held high with 8'hFF then 8'h01 -> frames separated by exactly one IDLE cycle; parity bits 0 then 1; frame_cnt=2.
REQ-032 rst pulsed during bit 4 of 8'h3C -> x=0, sactive=0 immediately; no done; frame_cnt unchanged at 0; next accept of 8'h3C transmits the full frame.
REQ-033 din_valid pulsed mid-frame with 8'hFF -> ignored; the in-flight frame is unchanged; no extra frame.
REQ-034 Macro undefined, din=8'hA5 -> 8-cycle frame 1,0,1,0,0,1,0,1, done on the next cycle; 256 frames -> frame_cnt wraps to 0.
